// File: rtl/data_ram_arbiter_if.sv
// data_ram_arbiter_if: one requester port of the data RAM arbiter.
// Carries a lock bit when DATA_ARB_LOCK_EN is defined.
interface data_ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        sel;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
`ifdef DATA_ARB_LOCK_EN
  logic              lock;

  modport master (
    output req, we, addr, sel, wdata, lock,
    input  ack, rdata
  );
  modport slave (
    input  req, we, addr, sel, wdata, lock,
    output ack, rdata
  );
`else
  modport master (
    output req, we, addr, sel, wdata,
    input  ack, rdata
  );
  modport slave (
    input  req, we, addr, sel, wdata,
    output ack, rdata
  );
`endif
endinterface

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: round-robin CPU/DMA arbiter for the single-port
// data RAM. Optional m1 bus lock under DATA_ARB_LOCK_EN.
module data_ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  data_ram_arbiter_if.slave m0,
  data_ram_arbiter_if.slave m1,
  output logic              stall_o,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_n;

  logic              owner;
  logic              last;
  logic              grant;
  logic              gsel;
  logic              r0;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

`ifdef DATA_ARB_LOCK_EN
  logic lock_q;
  logic lock_tx;

  // a held lock hides the CPU from the arbiter entirely
  assign r0 = m0.req & ~lock_q;
`else
  assign r0 = m0.req;
`endif

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    gsel    = 1'b0;
    unique case (state)
      IDLE: begin
        if (r0 | m1.req) begin
          grant   = 1'b1;
          state_n = ACCESS;
        end
        unique case (1'b1)
          (r0 & m1.req):  gsel = ~last;
          (m1.req & ~r0): gsel = 1'b1;
          default:        gsel = 1'b0;
        endcase
      end
      ACCESS:  state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_sel   <= '0;
      ram_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            owner     <= gsel;
            ram_ce    <= 1'b1;
            ram_we    <= gsel ? m1.we    : m0.we;
            ram_addr  <= gsel ? m1.addr  : m0.addr;
            ram_sel   <= gsel ? m1.sel   : m0.sel;
            ram_wdata <= gsel ? m1.wdata : m0.wdata;
          end
        end
        ACCESS: begin
          ram_ce <= 1'b0;
          ram_we <= 1'b0;
          if (!ram_we) begin
            if (owner) rdata1 <= ram_rdata;
            else       rdata0 <= ram_rdata;
          end
        end
        RESP:    last <= owner;
        default: ;
      endcase
    end
  end

`ifdef DATA_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q  <= 1'b0;
      lock_tx <= 1'b0;
    end else begin
      if (grant & gsel) begin
        lock_tx <= m1.lock;
        if (m1.lock) lock_q <= 1'b1;
      end
      if (state == RESP && owner && !lock_tx)
        lock_q <= 1'b0;
    end
  end
`endif

  assign m0.ack   = (state == RESP) & ~owner;
  assign m1.ack   = (state == RESP) & owner;
  assign m0.rdata = rdata0;
  assign m1.rdata = rdata1;
  assign stall_o  = m0.req & ~m0.ack;

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the single-port data RAM.
- Requester 0 is the CPU MEM stage; requester 1 is the debug/DMA loader.
- Latches one request at a time, drives the RAM chip-enable, write-enable, address, byte-select and write-data for exactly one cycle, then returns read data with a one-cycle ack.
- Round-robin fairness between requesters; generates a pipeline stall request for the CPU side.

Parameters:
- ADDR_W, 32, width of the requester and RAM address buses.
- DATA_W, 32, data width; fixed at 4 bytes because sel is 4 bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  CPU request; held high until m0_ack.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  byte address.
- m0_sel  in  4  byte enables; bit3 = data[31:24].
- m0_wdata  in  DATA_W  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_W  read data, valid while m0_ack is high.
- m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_ack, m1_rdata: same as m0 for the DMA/debug side.
- stall_o  out  1  m0_req & ~m0_ack; stalls the CPU pipeline.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_sel  out  4  RAM byte enables.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  combinational RAM read data; valid while ram_ce=1 and ram_we=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last=1 (m0 wins the first tie).
  - All acks 0; ram_ce, ram_we 0; ram_addr, ram_sel, ram_wdata 0; m0_rdata, m1_rdata 0.
  - A reset during ACCESS or RESP aborts the access, and no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that requester.
  - Both req: grant the requester other than last.
  - On grant, register owner, we, addr, sel and wdata into the RAM output registers; go to ACCESS.
- ACCESS (exactly one cycle):
  - ram_ce=1; other RAM outputs hold the latched values.
  - A write commits in the RAM at the closing edge.
  - A read captures ram_rdata into owner's rdata register at the closing edge.
  - Go to RESP.
- RESP (one cycle):
  - Owner's ack=1; ram_ce=0, ram_we=0.
  - On a write, rdata holds its previous value.
  - last<=owner; go to IDLE.
- Latency: req sampled high at edge N gives ACCESS in cycle N+1 and ack in cycle N+2. Back-to-back throughput is one access per 3 cycles.
- Requester rules:
  - Drop req in the ack cycle or earlier.
  - A req still high in the cycle after ack is treated as a new request.
  - Request fields are latched, so changing or dropping req after the grant does not cancel the access; the ack is still issued.
- Acks are never asserted simultaneously. The non-owner's ack and rdata are unchanged.
- Addresses and sel pass through unmodified; alignment checks belong to the requester.
- stall_o is combinational. With m0_req=1, stall_o is 0 only in m0's ack cycle.

Optional Feature:
- Macro: DATA_ARB_LOCK_EN.
- Defined:
  - Adds input m1_lock (1 bit), sampled with the m1 request fields at grant.
  - If an m1 transaction is granted with m1_lock=1, a lock flag sets.
  - While the flag is set, IDLE ignores m0_req and grants only m1.
  - The flag clears in the RESP of an m1 transaction granted with m1_lock=0, or on reset.
  - Used for atomic read-modify-write and for DMA bursts.
- Undefined: no m1_lock port; pure round-robin as above.

Test Plan:
- m0 read: m0_req=1, we=0, addr=0x10 after reset (RAM word 0x10 = 0xDEADBEEF) -> ram_ce=1 with ram_addr=0x10 in cycle 2; m0_ack=1 and m0_rdata=0xDEADBEEF in cycle 3; stall_o=1 in cycles 1-2.
- m1 byte write: m1 writes 0x000000AA with sel=0001 to 0x20, then m1 reads 0x20 -> ram_we=1 with ram_sel=0001 in ACCESS; the read returns the prior upper bytes with low byte 0xAA.
- Both req held high, continuous -> grants alternate m0, m1, m0, m1; each ack arrives 3 cycles apart.
- Reset pulse during ACCESS of an m0 write -> no m0_ack; ram_ce=0 immediately; state=IDLE; next tie is granted to m0.
- m0 drops req in cycle 1 after the grant -> access still completes and m0_ack pulses in cycle 2.
- DATA_ARB_LOCK_EN: m1 does 3 locked accesses with m0_req high throughout -> m1 served 3 times consecutively, then m1 unlocked, then m0 granted next.
